// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
// Glyph bit 0 is segment a, bit 6 is segment g, active-high.
package seg_pkg;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_COMMIT
    } state_e;

    function automatic int bcd_digits(input int data_w);
        return (data_w + 2) / 3 + 1;
    endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble: one adjust-and-shift step per clock.
// done is high during the final step; bcd is valid from the next cycle.
module seg_bin2bcd
    import seg_pkg::*;
#(
    parameter int DATA_W = 16,
    localparam int BCD_W = 4 * bcd_digits(DATA_W)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sr_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  adj;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        adj = bcd_q;
        for (int j = 0; j < BCD_W / 4; j++) begin
            if (bcd_q[4*j +: 4] >= 4'd5) begin
                adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            sr_q  <= bin;
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            bcd_q <= {adj[BCD_W-2:0], sr_q[DATA_W-1]};
            sr_q  <= sr_q << 1;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done = (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode 7-segment driver with hex/decimal display,
// leading-zero blanking, double-buffered frames and anti-ghost dead time.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DATA_W         = 16,
    parameter int SCAN_DIV       = 1024,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    input  logic                  mode_dec,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  lz_blank,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_W = 4 * bcd_digits(DATA_W);
    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam int EXT_W = DATA_W + BCD_W + DIG_W;
    localparam int PS_W  = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    state_e state_q, state_d;

    logic                  launch, conv_start, conv_done, commit;
    logic [DATA_W-1:0]     req_val;
    logic                  req_dec, req_lz;
    logic [NUM_DIGITS-1:0] req_dp;
    logic [BCD_W-1:0]      bcd;

    logic [DATA_W-1:0]     cur_val_q, pend_val_q;
    logic                  cur_dec_q, pend_dec_q;
    logic                  cur_lz_q, pend_lz_q;
    logic [NUM_DIGITS-1:0] cur_dp_q, pend_dp_q;
    logic                  pend_vld_q;

    logic [EXT_W-1:0]      sel_ext;
    logic [DIG_W-1:0]      new_dig;
    logic                  new_ovf;

    logic [DIG_W-1:0]      back_dig_q, front_dig_q;
    logic [NUM_DIGITS-1:0] back_dp_q, front_dp_q;
    logic                  back_lz_q, front_lz_q;
    logic                  back_ovf_q, front_ovf_q;

    logic [PS_W-1:0]       presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wrap_slot, frame_wrap;
    logic [NUM_DIGITS-1:0] dig_q, dig_d, onehot;
    logic [7:0]            seg_q, seg_d, seg_raw;
    logic [DIG_W-1:0]      sh;
    logic [6:0]            g7;
    logic                  blank;

    // A load in the commit cycle is newer than anything pending
    always_comb begin
        req_val = load ? value    : pend_val_q;
        req_dec = load ? mode_dec : pend_dec_q;
        req_dp  = load ? dp_mask  : pend_dp_q;
        req_lz  = load ? lz_blank : pend_lz_q;
        launch  = (state_q == ST_IDLE && load) ||
                  (state_q == ST_COMMIT && (load || pend_vld_q));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = req_dec ? ST_CONVERT : ST_COMMIT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (launch) begin
                    state_d = req_dec ? ST_CONVERT : ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        commit     = (state_q == ST_COMMIT);
        conv_start = launch && req_dec;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_val_q  <= '0;
            cur_dec_q  <= 1'b0;
            cur_dp_q   <= '0;
            cur_lz_q   <= 1'b0;
            pend_val_q <= '0;
            pend_dec_q <= 1'b0;
            pend_dp_q  <= '0;
            pend_lz_q  <= 1'b0;
            pend_vld_q <= 1'b0;
        end else if (launch) begin
            cur_val_q  <= req_val;
            cur_dec_q  <= req_dec;
            cur_dp_q   <= req_dp;
            cur_lz_q   <= req_lz;
            pend_vld_q <= 1'b0;
        end else if (load) begin
            pend_val_q <= value;
            pend_dec_q <= mode_dec;
            pend_dp_q  <= dp_mask;
            pend_lz_q  <= lz_blank;
            pend_vld_q <= 1'b1;
        end
    end

    seg_bin2bcd #(
        .DATA_W(DATA_W)
    ) u_bin2bcd (
        .CLK  (CLK),
        .RST_N(RST_N),
        .start(conv_start),
        .bin  (req_val),
        .done (conv_done),
        .bcd  (bcd)
    );

    // Anything that does not fit in the visible digits is overflow
    always_comb begin
        sel_ext = cur_dec_q ? EXT_W'(bcd) : EXT_W'(cur_val_q);
        new_dig = sel_ext[DIG_W-1:0];
        new_ovf = (sel_ext >> DIG_W) != '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            back_dig_q  <= '0;
            back_dp_q   <= '0;
            back_lz_q   <= 1'b1;
            back_ovf_q  <= 1'b0;
            front_dig_q <= '0;
            front_dp_q  <= '0;
            front_lz_q  <= 1'b1;
            front_ovf_q <= 1'b0;
        end else begin
            if (commit) begin
                back_dig_q <= new_dig;
                back_dp_q  <= cur_dp_q;
                back_lz_q  <= cur_lz_q;
                back_ovf_q <= new_ovf;
            end
            if (frame_wrap) begin
                front_dig_q <= back_dig_q;
                front_dp_q  <= back_dp_q;
                front_lz_q  <= back_lz_q;
                front_ovf_q <= back_ovf_q;
            end
        end
    end

    always_comb begin
        wrap_slot  = (presc_q == PS_W'(SCAN_DIV - 1));
        frame_wrap = wrap_slot && (idx_q == IDX_W'(NUM_DIGITS - 1));
        presc_d    = wrap_slot ? '0 : presc_q + PS_W'(1);
        idx_d      = idx_q;
        if (wrap_slot) begin
            idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
        end
        onehot = NUM_DIGITS'(1) << idx_d;
        dig_d  = DIG_OFF;
        if (presc_d >= PS_W'(BLANK_CYCLES)) begin
            dig_d = DIG_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    // Digit is blank when it and every digit above it are zero
    always_comb begin
        sh    = front_dig_q >> (4 * idx_q);
        blank = front_lz_q && (idx_q != '0) && (sh == '0);
        if (front_ovf_q) begin
            g7 = GLYPH_DASH;
        end else if (blank) begin
            g7 = GLYPH_BLANK;
        end else begin
            g7 = GLYPH[sh[3:0]];
        end
        seg_raw = {front_dp_q[idx_q], g7};
        seg_d   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q <= '0;
            idx_q   <= '0;
            dig_q   <= DIG_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            if (presc_q == '0) begin
                seg_q <= seg_d;
            end
        end
    end

    assign seg      = seg_q;
    assign dig      = dig_q;
    assign overflow = back_ovf_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: timestamp/arithmetic display model checked
// every cycle, plus literal segment patterns for the key scenarios.
module tb_seg_scan_display;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = SD * N;

    localparam logic [6:0] GL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] value = '0;
    logic         load = 1'b0;
    logic         mode_dec = 1'b0;
    logic [N-1:0] dp_mask = '0;
    logic         lz_blank = 1'b0;
    logic [7:0]   seg;
    logic [N-1:0] dig;
    logic         busy;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 CLK = ~CLK;

    seg_scan_display #(
        .NUM_DIGITS    (N),
        .DATA_W        (W),
        .SCAN_DIV      (SD),
        .BLANK_CYCLES  (BL),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .value   (value),
        .load    (load),
        .mode_dec(mode_dec),
        .dp_mask (dp_mask),
        .lz_blank(lz_blank),
        .seg     (seg),
        .dig     (dig),
        .busy    (busy),
        .overflow(overflow)
    );

    typedef struct packed {
        logic [W-1:0] v;
        logic         dec;
        logic [N-1:0] dp;
        logic         lz;
    } job_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int pw(input int b, input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * b;
        return r;
    endfunction

    function automatic logic job_ovf(input job_t j);
        return int'(j.v) >= (j.dec ? pw(10, N) : pw(16, N));
    endfunction

    function automatic logic [7:0] exp_seg(input job_t j, input int i);
        int b = j.dec ? 10 : 16;
        int v = int'(j.v);
        logic [6:0] g;
        if (job_ovf(j)) g = 7'h40;
        else if (j.lz && i > 0 && v < pw(b, i)) g = 7'h00;
        else g = GL[(v / pw(b, i)) % b];
        return ~{j.dp[i], g};
    endfunction

    job_t back_m, front_m, cur_m, pend_m;
    logic act_m, pv_m;
    int   m, commit_e;

    task automatic start_job(input job_t j);
        cur_m    = j;
        act_m    = 1'b1;
        commit_e = m + (j.dec ? W + 1 : 1);
    endtask

    // Edge-count model: commits land a fixed number of edges after launch
    always @(posedge CLK or negedge RST_N) begin
        job_t inj;
        if (!RST_N) begin
            m       = 0;
            back_m  = '{v: '0, dec: 1'b0, dp: '0, lz: 1'b1};
            front_m = back_m;
            act_m   = 1'b0;
            pv_m    = 1'b0;
        end else begin
            inj = '{v: value, dec: mode_dec, dp: dp_mask, lz: lz_blank};
            m++;
            if (m % FRAME == 0) front_m = back_m;
            if (act_m && m == commit_e) begin
                back_m = cur_m;
                act_m  = 1'b0;
                if (load) begin
                    start_job(inj);
                    pv_m = 1'b0;
                end else if (pv_m) begin
                    start_job(pend_m);
                    pv_m = 1'b0;
                end
            end else if (!act_m && load) begin
                start_job(inj);
            end else if (act_m && load) begin
                pend_m = inj;
                pv_m   = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        int p, ix;
        logic [N-1:0] ed;
        if (!RST_N) begin
            chk("rst_seg", seg, 8'hFF);
            chk("rst_dig", dig, 4'hF);
            chk("rst_busy", busy, 1'b0);
            chk("rst_ovf", overflow, 1'b0);
        end else begin
            p  = m % SD;
            ix = (m / SD) % N;
            ed = (p >= BL) ? ~(N'(1) << ix) : '1;
            chk("dig", dig, ed);
            chk("busy", busy, act_m);
            chk("ovf", overflow, job_ovf(back_m));
            if (p >= BL) chk("seg", seg, exp_seg(front_m, ix));
        end
    end

    task automatic do_load(input logic [W-1:0] v, input logic dec,
                           input logic [N-1:0] dp, input logic lz);
        @(negedge CLK);
        value    = v;
        mode_dec = dec;
        dp_mask  = dp;
        lz_blank = lz;
        load     = 1'b1;
        @(negedge CLK);
        load = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge CLK);
        end
    endtask

    task automatic settle();
        repeat (2 * FRAME + W + 4) @(negedge CLK);
    endtask

    task automatic seg_at(input int d, input logic [7:0] exp,
                          input string nm);
        int k = 0;
        while (dig !== ~(N'(1) << d) && k < 4 * FRAME) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 4 * FRAME) begin
            checks++;
            errors++;
            $display("FAIL %s digit %0d never enabled, want seg %0h",
                     nm, d, exp);
        end else begin
            chk(nm, seg, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        seg_at(0, 8'hC0, "rst_d0");
        seg_at(1, 8'hFF, "rst_d1");
        seg_at(3, 8'hFF, "rst_d3");

        do_load(16'd1234, 1'b1, 4'b0000, 1'b0);
        count_busy(n);
        chk("busy_len_dec", n, 17);
        settle();
        seg_at(3, 8'hF9, "dec_d3");
        seg_at(0, 8'h99, "dec_d0");
        chk("dec_ovf", overflow, 1'b0);

        do_load(16'h00AF, 1'b0, 4'b0100, 1'b1);
        count_busy(n);
        chk("busy_len_hex", n, 1);
        settle();
        seg_at(0, 8'h8E, "hex_d0");
        seg_at(1, 8'h88, "hex_d1");
        seg_at(2, 8'h7F, "hex_d2_dp");
        seg_at(3, 8'hFF, "hex_d3");

        do_load(16'd10000, 1'b1, 4'b0000, 1'b1);
        settle();
        chk("ovf_set", overflow, 1'b1);
        seg_at(0, 8'hBF, "ovf_d0");
        seg_at(3, 8'hBF, "ovf_d3");

        do_load(16'd7, 1'b1, 4'b0000, 1'b1);
        settle();
        chk("ovf_clr", overflow, 1'b0);
        seg_at(0, 8'hF8, "seven_d0");
        seg_at(3, 8'hFF, "seven_d3");

        do_load(16'd5, 1'b1, 4'b0000, 1'b1);
        do_load(16'd6, 1'b1, 4'b0000, 1'b1);
        do_load(16'd9, 1'b1, 4'b0000, 1'b1);
        settle();
        seg_at(0, 8'h90, "pend_d0");

        do_load(16'd1234, 1'b1, 4'b0000, 1'b0);
        repeat (5) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_dig", dig, 4'hF);
        chk("midrst_seg", seg, 8'hFF);
        @(negedge CLK);
        RST_N = 1'b1;
        settle();
        seg_at(0, 8'hC0, "post_d0");
        seg_at(3, 8'hFF, "post_d3");
        chk("post_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised multiplexed 7-segment driver for NUM_DIGITS common-anode digits.
- Accepts a binary value on a load strobe and shows it in hex or decimal, with leading-zero blanking and per-digit decimal points.
- Decimal conversion is a sequential double-dabble; the scan adds anti-ghosting dead time.
- Sits between application logic and the board's segment/digit pins, replacing fixed single-digit combinational decoding.

Parameters:
- NUM_DIGITS, 4: number of physical digits (1..8).
- DATA_W, 16: width of the input value.
- SCAN_DIV, 1024: CLK cycles per digit slot (>= 2*BLANK_CYCLES).
- BLANK_CYCLES, 16: cycles at the start of each slot with all digit enables off.
- SEG_ACTIVE_LOW, 1: invert seg outputs when 1.
- DIG_ACTIVE_LOW, 1: invert dig outputs when 1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- value  in  DATA_W  binary value to display.
- load  in  1  single-cycle strobe capturing value, mode_dec, dp_mask, lz_blank.
- mode_dec  in  1  1 = decimal, 0 = hex.
- dp_mask  in  NUM_DIGITS  bit i lights the DP of digit i (digit 0 = rightmost).
- lz_blank  in  1  blank leading zeros.
- seg  out  8  bits [6:0] = segments a..g, bit 7 = dp.
- dig  out  NUM_DIGITS  one-hot digit enable.
- busy  out  1  conversion in progress.
- overflow  out  1  committed value does not fit NUM_DIGITS.

Behaviour:
- Reset (async assert, sync release):
  - seg and dig at their "off" levels per the polarity parameters; busy=0, overflow=0.
  - Front buffer = zero with lz_blank=1, dp_mask=0, so the first frame shows "   0".
  - Scan index=0, prescaler=0, FSM=IDLE.
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE, load=1: capture all inputs.
    - Hex: go to COMMIT next cycle.
    - Decimal: go to CONVERT and start seg_bin2bcd.
  - CONVERT: exactly DATA_W cycles of shift plus add-3. busy=1 from the cycle after load until COMMIT ends.
  - COMMIT (1 cycle):
    - Write digits, dp_mask, lz_blank and overflow into the back buffer.
    - Return to IDLE.
    - If a pending load exists, immediately start it instead.
- Load while busy:
  - Stored in a one-deep pending slot; the latest load wins and earlier pending loads are dropped.
  - It never aborts the current conversion.
- Latency from load to back buffer: hex 2 cycles; decimal DATA_W+2 cycles.
- Overflow:
  - Decimal: any BCD digit above NUM_DIGITS-1 is nonzero. Internal BCD width is ceil(DATA_W/3)+1 digits.
  - Hex: any value bit at or above 4*NUM_DIGITS is set.
  - On overflow, every digit shows "-" (segment g only), DPs still follow dp_mask, overflow=1 until the next commit.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1; the slot index advances on wrap; index NUM_DIGITS-1 wraps to 0.
  - dig is all off while prescaler < BLANK_CYCLES; otherwise only dig[index] is on.
  - seg is registered and changes only at slot start, while dig is off.
- Buffer swap:
  - Back buffer copies to the front buffer only when the index wraps to 0. No tearing within a frame.
  - Commit and swap in the same cycle: the swap takes the old back buffer; the new data appears next frame.
- Glyphs: 0-9 standard; A, b, C, d, E, F for 10-15; "-" = g only; blank = none. Active-high internally, inverted at the output if SEG_ACTIVE_LOW.
- Leading-zero blanking (lz_blank=1): zero digits above the highest nonzero digit are blank. Digit 0 is never blanked. A DP on a blanked digit is still lit.
- Reset mid-conversion: conversion is discarded, pending load cleared, display returns to the reset state.

Decomposition:
- Shared package seg_pkg:
  - 16-entry glyph constant array plus GLYPH_DASH and GLYPH_BLANK.
  - FSM state enum.
  - Function computing BCD digit count from DATA_W.
- Sub-module seg_bin2bcd: sequential double-dabble.
  - Ports: CLK, RST_N, start, bin, done, bcd.
  - Parametrised by DATA_W.

Test Plan:
- Reset release with SCAN_DIV=8, BLANK_CYCLES=2 -> dig cycles 0..3, each slot's first 2 cycles all off; digit 0 shows "0" (seg=8'b11000000); digits 1-3 show 8'hFF.
- Load 16'd1234, decimal, lz_blank=0 -> busy for 17 cycles; next frame shows 1,2,3,4 with the left digit = "1"; overflow=0.
- Load 16'h00AF, hex, lz_blank=1, dp_mask=4'b0100 -> digits "  AF"; digit 2 blank with DP lit; commit 2 cycles after load.
- Load 16'd10000, decimal -> all digits "-" (seg=8'b10111111), overflow=1; then load 16'd7 -> overflow clears, display "   7".
- Load 16'd5, then 16'd6, then 16'd9 while busy -> shows 5, then 9; 6 never committed.
- Assert RST_N low mid-CONVERT -> busy=0 immediately; after release, display returns to "   0" and there is no commit.
